// File: rtl/seq_signed_div.sv
// Iterative radix-2 restoring divider: signed or unsigned, one quotient bit per cycle.
// A start/busy/done handshake accepts one division at a time; results hold until the next one.
module seq_signed_div #(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 8,
  parameter int CNT_WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               tc,
  input  logic [A_WIDTH-1:0] dat_a,
  input  logic [B_WIDTH-1:0] dat_b,
  output logic               busy,
  output logic               done,
  output logic [A_WIDTH-1:0] quotient,
  output logic [B_WIDTH-1:0] remainder,
  output logic               div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(A_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [A_WIDTH-1:0]   A_ONE    = A_WIDTH'(1);
  localparam logic [B_WIDTH-1:0]   B_ONE    = B_WIDTH'(1);

  state_t               state, state_nxt;
  logic                 busy_nxt, done_nxt;
  logic                 tc_r, sa_r, sb_r;
  logic [B_WIDTH-1:0]   a_raw_lo_r;
  logic [A_WIDTH-1:0]   a_sh_r;
  logic [B_WIDTH-1:0]   b_mag_r;
  logic [B_WIDTH:0]     prem_r;
  logic [CNT_WIDTH-1:0] cnt_r;

  logic [B_WIDTH+1:0]   shifted;
  logic [B_WIDTH+1:0]   diff;
  logic                 neg;

  function automatic logic [A_WIDTH-1:0] cneg_a(input logic [A_WIDTH-1:0] v, input logic en);
    return en ? (~v + A_ONE) : v;
  endfunction

  function automatic logic [B_WIDTH-1:0] cneg_b(input logic [B_WIDTH-1:0] v, input logic en);
    return en ? (~v + B_ONE) : v;
  endfunction

  // Restoring step: shift the next dividend bit in, trial-subtract, keep or restore.
  always_comb begin
    shifted = {prem_r, a_sh_r[A_WIDTH-1]};
    diff    = shifted - {2'b00, b_mag_r};
    neg     = diff[B_WIDTH+1];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt_r == LAST_CNT) state_nxt = SIGN;
      SIGN:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  // Datapath: a_sh_r holds the dividend magnitude and fills with quotient bits as it drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tc_r        <= 1'b0;
      sa_r        <= 1'b0;
      sb_r        <= 1'b0;
      a_raw_lo_r  <= '0;
      a_sh_r      <= '0;
      b_mag_r     <= '0;
      prem_r      <= '0;
      cnt_r       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            tc_r       <= tc;
            sa_r       <= dat_a[A_WIDTH-1];
            sb_r       <= dat_b[B_WIDTH-1];
            a_raw_lo_r <= dat_a[B_WIDTH-1:0];
            a_sh_r     <= cneg_a(dat_a, tc & dat_a[A_WIDTH-1]);
            b_mag_r    <= cneg_b(dat_b, tc & dat_b[B_WIDTH-1]);
            prem_r     <= '0;
            cnt_r      <= '0;
          end
        end
        CALC: begin
          prem_r <= neg ? shifted[B_WIDTH:0] : diff[B_WIDTH:0];
          a_sh_r <= {a_sh_r[A_WIDTH-2:0], ~neg};
          cnt_r  <= cnt_r + CNT_ONE;
        end
        SIGN: begin
          if (b_mag_r == '0) begin
            quotient    <= '1;
            remainder   <= a_raw_lo_r;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= cneg_a(a_sh_r, tc_r & (sa_r ^ sb_r));
            remainder   <= cneg_b(prem_r[B_WIDTH-1:0], tc_r & sa_r);
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_signed_div.sv
// Directed bench for seq_signed_div (A_WIDTH=16, B_WIDTH=8) with hand-computed results.
module tb_seq_signed_div;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        tc = 1'b0;
  logic [15:0] dat_a = '0;
  logic [7:0]  dat_b = '0;
  logic        busy, done, div_by_zero;
  logic [15:0] quotient;
  logic [7:0]  remainder;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  seq_signed_div #(.A_WIDTH(16), .B_WIDTH(8), .CNT_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tc(tc), .dat_a(dat_a), .dat_b(dat_b),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One division: start presented before edge 1, done expected after edge 18.
  task automatic do_div(input string tag, input logic t, input logic [15:0] a, input logic [7:0] b,
                        input logic [15:0] eq, input logic [7:0] er, input logic edz);
    int  n;
    bit  got;
    @(negedge clk);
    chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
    tc = t; dat_a = a; dat_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
    n = 1; got = 1'b0;
    while (n < 40 && !got) begin
      @(posedge clk); #1;
      n++;
      if (done) got = 1'b1;
    end
    chk({tag, "_lat"}, n, 32'd18);
    chk({tag, "_q"}, {16'b0, quotient}, {16'b0, eq});
    chk({tag, "_r"}, {24'b0, remainder}, {24'b0, er});
    chk({tag, "_dz"}, {31'b0, div_by_zero}, {31'b0, edz});
    @(posedge clk); #1;
    chk({tag, "_pulse"}, {30'b0, done, busy}, 32'd0);
    chk({tag, "_hold"}, {16'b0, quotient}, {16'b0, eq});
  endtask

  initial begin
    int idle_cnt, n_done, n;
    bit prev_done, got;

    #2;
    chk("rst_state", {6'b0, busy, done, quotient, remainder}, 32'd0);
    chk("rst_dz", {31'b0, div_by_zero}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);

    do_div("u1", 1'b0, 16'h03E8, 8'h07, 16'h008E, 8'h06, 1'b0);
    do_div("u2", 1'b0, 16'hFC18, 8'hF9, 16'h0103, 8'h2D, 1'b0);
    do_div("s_np", 1'b1, 16'hFC18, 8'h07, 16'hFF72, 8'hFA, 1'b0);
    do_div("s_pn", 1'b1, 16'h03E8, 8'hF9, 16'hFF72, 8'h06, 1'b0);
    do_div("s_nn", 1'b1, 16'hFC18, 8'hF9, 16'h008E, 8'hFA, 1'b0);
    do_div("ovf", 1'b1, 16'h8000, 8'hFF, 16'h8000, 8'h00, 1'b0);
    do_div("min_min", 1'b1, 16'h8000, 8'h80, 16'h0100, 8'h00, 1'b0);
    do_div("max_max", 1'b1, 16'h7FFF, 8'h7F, 16'h0102, 8'h01, 1'b0);
    do_div("dz_u", 1'b0, 16'h1234, 8'h00, 16'hFFFF, 8'h34, 1'b1);
    do_div("dz_s", 1'b1, 16'h1234, 8'h00, 16'hFFFF, 8'h34, 1'b1);
    do_div("after_dz", 1'b0, 16'h03E8, 8'h07, 16'h008E, 8'h06, 1'b0);
    do_div("zero_a", 1'b1, 16'h0000, 8'h05, 16'h0000, 8'h00, 1'b0);

    // Start held high for 40 cycles with inputs scrambled whenever the divider is busy.
    idle_cnt = 0; n_done = 0; prev_done = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (!busy) idle_cnt++;
      if (i == 1) begin
        tc = 1'b0; dat_a = 16'h03E8; dat_b = 8'h07;
      end else if (i == 20) begin
        chk("hs_idle20", {31'b0, busy}, 32'd0);
        tc = 1'b1; dat_a = 16'hFC18; dat_b = 8'hF9;
      end else begin
        tc = 1'($urandom_range(0, 1)); dat_a = 16'($urandom); dat_b = 8'($urandom);
      end
      start = 1'b1;
      @(posedge clk); #1;
      chk("hs_single", {31'b0, done & prev_done}, 32'd0);
      if (done) begin
        n_done++;
        chk("hs_q", {16'b0, quotient}, (n_done == 1) ? 32'h008E : 32'h008E);
        chk("hs_r", {24'b0, remainder}, (n_done == 1) ? 32'h06 : 32'hFA);
        chk("hs_at", i, (n_done == 1) ? 32'd18 : 32'd37);
      end
      prev_done = done;
    end
    start = 1'b0;
    chk("hs_ndone", n_done, 32'd2);
    chk("hs_idle", idle_cnt, 32'd3);
    n = 0; got = 1'b0;
    while (n < 30 && !got) begin
      @(posedge clk); #1;
      n++;
      if (done) got = 1'b1;
    end
    chk("hs_third_done", {31'b0, got}, 32'd1);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of CALC iteration 5.
    @(negedge clk);
    tc = 1'b0; dat_a = 16'h03E8; dat_b = 8'h07; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    chk("pre_rst_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_ctl", {30'b0, busy, done}, 32'd0);
    chk("arst_out", {7'b0, div_by_zero, quotient, remainder}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    chk("arst_no_done", n_done, 32'd0);
    chk("arst_idle", {31'b0, busy}, 32'd0);
    do_div("post_rst", 1'b0, 16'h03E8, 8'h07, 16'h008E, 8'h06, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
